// File: rtl/tmds_encoder_multi.sv
// tmds_encoder_multi
//   Multi-lane TMDS encoder for the HDMI output path. All NCH lanes are
//   encoded in lock-step from one shared period type. The pipeline is three
//   i_ce-qualified stages:
//     stage 1 registers the inputs and the pixel transition-minimised word q_m,
//     stage 2 applies the running-disparity choice and builds the non-pixel
//             symbol,
//     stage 3 selects the symbol by period type and applies the bit order.
//   The running disparity is forced to 0 whenever stage 2 carries a
//   non-pixel period, so every video period starts balanced.
// Ports
//   i_clk        pixel clock
//   i_reset      asynchronous active-high reset
//   i_ce         pipeline advance enable; all state holds while low
//   i_dtype      00 guard band, 01 control, 10 data island (TERC4), 11 pixel
//   i_di_guard   with dtype 00: 0 video guard band, 1 data-island guard band
//   i_ctl        per-lane {C1,C0}
//   i_aux        per-lane TERC4 nibble
//   i_data       per-lane pixel byte
//   o_word       per-lane 10-bit symbol, lane k at [10k+9:10k]
//   o_disparity  per-lane signed running disparity after the symbol on o_word
module tmds_encoder_multi #(
    parameter int NCH            = 3,
    parameter bit OPT_BITREVERSE = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_ce,
    input  logic [1:0]         i_dtype,
    input  logic               i_di_guard,
    input  logic [2*NCH-1:0]   i_ctl,
    input  logic [4*NCH-1:0]   i_aux,
    input  logic [8*NCH-1:0]   i_data,
    output logic [10*NCH-1:0]  o_word,
    output logic [5*NCH-1:0]   o_disparity
);

    localparam logic [1:0] DT_GUARD  = 2'b00;
    localparam logic [1:0] DT_CTL    = 2'b01;
    localparam logic [1:0] DT_ISLAND = 2'b10;
    localparam logic [1:0] DT_PIXEL  = 2'b11;

    localparam logic [9:0] SYM_CTL0 = 10'b1101010100;
    localparam logic [9:0] GB_A     = 10'b1011001100;
    localparam logic [9:0] GB_B     = 10'b0100110011;

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            2'b11:   s = 10'b1010101011;
            default: s = 10'b1101010100;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] n);
        logic [9:0] s;
        case (n)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            4'hF:    s = 10'b1011000011;
            default: s = 10'b1010011100;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Transition-minimised word; bit 8 set means the XOR chain was used.
    function automatic logic [8:0] qm_encode(input logic [7:0] d);
        logic [8:0] q;
        logic       use_xnor;
        logic [3:0] n1;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor) begin
                q[i] = ~(q[i-1] ^ d[i]);
            end else begin
                q[i] = q[i-1] ^ d[i];
            end
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Reversed order puts symbol bit 9 at word bit 0 so the serialiser sends MSB-first.
    function automatic logic [9:0] bit_order(input logic [9:0] s);
        logic [9:0] r;
        r = s;
        if (OPT_BITREVERSE) begin
            for (int j = 0; j < 10; j++) begin
                r[j] = s[9-j];
            end
        end else begin
            r = s;
        end
        return r;
    endfunction

    // Stage 1 state
    logic [1:0]         s1_dtype_q;
    logic               s1_di_guard_q;
    logic [2*NCH-1:0]   s1_ctl_q;
    logic [4*NCH-1:0]   s1_aux_q;
    logic [8:0]         s1_qm_q [NCH];
    logic [8:0]         s1_qm_d [NCH];

    // Stage 2 state
    logic [1:0]         s2_dtype_q;
    logic [9:0]         s2_pix_q [NCH];
    logic [9:0]         s2_pix_d [NCH];
    logic [9:0]         s2_oth_q [NCH];
    logic [9:0]         s2_oth_d [NCH];
    logic signed [4:0]  cnt_q    [NCH];
    logic signed [4:0]  cnt_d    [NCH];

    // Stage 2 working values
    logic [3:0]         n1_s     [NCH];
    logic [3:0]         n0_s     [NCH];
    logic signed [4:0]  diff_s   [NCH];
    logic signed [4:0]  pix_cnt_s[NCH];

    // Stage 3 state
    logic [10*NCH-1:0]  word_q, word_d;
    logic [5*NCH-1:0]   disp_q, disp_d;

    // Stage 1: per-lane q_m from the raw pixel byte.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            s1_qm_d[k] = qm_encode(i_data[8*k +: 8]);
        end
    end

    // Stage 2: disparity-driven pixel symbol and next running disparity.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            n1_s[k]   = ones8(s1_qm_q[k][7:0]);
            n0_s[k]   = 4'd8 - n1_s[k];
            diff_s[k] = $signed({1'b0, n1_s[k]}) - $signed({1'b0, n0_s[k]});
            if ((cnt_q[k] == 5'sd0) || (n1_s[k] == n0_s[k])) begin
                s2_pix_d[k]  = {~s1_qm_q[k][8], s1_qm_q[k][8],
                                s1_qm_q[k][8] ? s1_qm_q[k][7:0] : ~s1_qm_q[k][7:0]};
                pix_cnt_s[k] = cnt_q[k] + (s1_qm_q[k][8] ? diff_s[k] : -diff_s[k]);
            end else if (((cnt_q[k] > 5'sd0) && (n1_s[k] > n0_s[k])) ||
                         ((cnt_q[k] < 5'sd0) && (n0_s[k] > n1_s[k]))) begin
                s2_pix_d[k]  = {1'b1, s1_qm_q[k][8], ~s1_qm_q[k][7:0]};
                pix_cnt_s[k] = cnt_q[k] + (s1_qm_q[k][8] ? 5'sd2 : 5'sd0) - diff_s[k];
            end else begin
                s2_pix_d[k]  = {1'b0, s1_qm_q[k][8], s1_qm_q[k][7:0]};
                pix_cnt_s[k] = cnt_q[k] + (s1_qm_q[k][8] ? diff_s[k] : diff_s[k] - 5'sd2);
            end
            // Outside video the count is parked at zero so the next period starts balanced.
            if (s1_dtype_q == DT_PIXEL) begin
                cnt_d[k] = pix_cnt_s[k];
            end else begin
                cnt_d[k] = 5'sd0;
            end
        end
    end

    // Stage 2: control, TERC4 and guard-band symbols.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            s2_oth_d[k] = SYM_CTL0;
            case (s1_dtype_q)
                DT_GUARD: begin
                    if (s1_di_guard_q) begin
                        // Lane 0 keeps carrying sync inside the island guard band.
                        if (k == 0) begin
                            s2_oth_d[k] = terc4_sym({2'b11, s1_ctl_q[1:0]});
                        end else begin
                            s2_oth_d[k] = GB_B;
                        end
                    end else begin
                        if (k == 1) begin
                            s2_oth_d[k] = GB_B;
                        end else begin
                            s2_oth_d[k] = GB_A;
                        end
                    end
                end
                DT_CTL:    s2_oth_d[k] = ctl_sym(s1_ctl_q[2*k +: 2]);
                DT_ISLAND: s2_oth_d[k] = terc4_sym(s1_aux_q[4*k +: 4]);
                default:   s2_oth_d[k] = SYM_CTL0;
            endcase
        end
    end

    // Stage 3: period-type mux, bit order, disparity aligned with its symbol.
    always_comb begin
        word_d = '0;
        disp_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (s2_dtype_q == DT_PIXEL) begin
                word_d[10*k +: 10] = bit_order(s2_pix_q[k]);
            end else begin
                word_d[10*k +: 10] = bit_order(s2_oth_q[k]);
            end
            disp_d[5*k +: 5] = cnt_q[k];
        end
    end

    // Pipeline registers for all three stages; reset idles on control 00.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_dtype_q    <= DT_CTL;
            s1_di_guard_q <= 1'b0;
            s1_ctl_q      <= '0;
            s1_aux_q      <= '0;
            s2_dtype_q    <= DT_CTL;
            for (int k = 0; k < NCH; k++) begin
                s1_qm_q[k]         <= 9'd0;
                s2_pix_q[k]        <= 10'd0;
                s2_oth_q[k]        <= SYM_CTL0;
                cnt_q[k]           <= 5'sd0;
                word_q[10*k +: 10] <= bit_order(SYM_CTL0);
            end
            disp_q <= '0;
        end else if (i_ce) begin
            s1_dtype_q    <= i_dtype;
            s1_di_guard_q <= i_di_guard;
            s1_ctl_q      <= i_ctl;
            s1_aux_q      <= i_aux;
            s2_dtype_q    <= s1_dtype_q;
            for (int k = 0; k < NCH; k++) begin
                s1_qm_q[k]  <= s1_qm_d[k];
                s2_pix_q[k] <= s2_pix_d[k];
                s2_oth_q[k] <= s2_oth_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            word_q <= word_d;
            disp_q <= disp_d;
        end
    end

    assign o_word      = word_q;
    assign o_disparity = disp_q;

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// tb_tmds_encoder_multi
//   Directed bench for tmds_encoder_multi with NCH=3. Two instances share the
//   stimulus: one with reversed bit order, one without. Every driven vector
//   carries its hand-computed pre-reversal symbols and disparities; these are
//   queued and compared three advancing cycles later.
module tb_tmds_encoder_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [1:0]  dtype;
    logic        di_guard;
    logic [5:0]  ctl;
    logic [11:0] aux;
    logic [23:0] data;
    logic [29:0] word_r, word_n;
    logic [14:0] disp_r, disp_n;

    tmds_encoder_multi #(.NCH(3), .OPT_BITREVERSE(1'b1)) dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_dtype(dtype), .i_di_guard(di_guard),
        .i_ctl(ctl), .i_aux(aux), .i_data(data), .o_word(word_r), .o_disparity(disp_r)
    );

    tmds_encoder_multi #(.NCH(3), .OPT_BITREVERSE(1'b0)) dut_nr (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_dtype(dtype), .i_di_guard(di_guard),
        .i_ctl(ctl), .i_aux(aux), .i_data(data), .o_word(word_n), .o_disparity(disp_n)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] C0   = 10'b1101010100;
    localparam logic [9:0] C1   = 10'b0010101011;
    localparam logic [9:0] C2   = 10'b0101010100;
    localparam logic [9:0] C3   = 10'b1010101011;
    localparam logic [9:0] GA   = 10'b1011001100;
    localparam logic [9:0] GB   = 10'b0100110011;
    localparam logic [9:0] P00  = 10'b0100000000;
    localparam logic [9:0] P1S  = 10'b1111111111;
    localparam logic [9:0] PFF  = 10'b1000000000;

    logic [9:0] terc [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [29:0] q_w [$];
    logic [14:0] q_d [$];
    string       q_t [$];
    logic [29:0] last_w;
    logic [14:0] last_d;
    logic [3:0]  nib0, nib1, nib2;

    function automatic logic [29:0] rev30(input logic [29:0] w);
        logic [29:0] r;
        r = w;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 10; j++) begin
                r[10*k + j] = w[10*k + 9 - j];
            end
        end
        return r;
    endfunction

    function automatic logic [14:0] dsp(input int d2, input int d1, input int d0);
        logic [4:0] a, b, c;
        a = d2[4:0];
        b = d1[4:0];
        c = d0[4:0];
        return {a, b, c};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_out(input string tag, input logic [29:0] ew, input logic [14:0] ed);
        check_eq({tag, "/word_rev"}, {2'b00, word_r}, {2'b00, rev30(ew)});
        check_eq({tag, "/word_fwd"}, {2'b00, word_n}, {2'b00, ew});
        check_eq({tag, "/disp_rev"}, {17'd0, disp_r}, {17'd0, ed});
        check_eq({tag, "/disp_fwd"}, {17'd0, disp_n}, {17'd0, ed});
    endtask

    // The two entries stand for the reset contents of stages 1 and 2.
    task automatic preload();
        q_w.delete();
        q_d.delete();
        q_t.delete();
        for (int i = 0; i < 2; i++) begin
            q_w.push_back({C0, C0, C0});
            q_d.push_back(15'd0);
            q_t.push_back("flush");
        end
    endtask

    task automatic cyc(input logic [1:0] dt, input logic g, input logic [5:0] c,
                       input logic [11:0] a, input logic [23:0] d,
                       input logic [29:0] ew, input logic [14:0] ed, input string tag);
        string t;
        dtype    = dt;
        di_guard = g;
        ctl      = c;
        aux      = a;
        data     = d;
        ce       = 1'b1;
        q_w.push_back(ew);
        q_d.push_back(ed);
        q_t.push_back(tag);
        @(posedge clk);
        #1;
        if (q_w.size() >= 3) begin
            last_w = q_w.pop_front();
            last_d = q_d.pop_front();
            t      = q_t.pop_front();
            compare_out(t, last_w, last_d);
        end
    endtask

    // A non-advancing cycle with junk inputs must leave every output unchanged.
    task automatic stall(input string tag);
        ce       = 1'b0;
        dtype    = 2'($urandom);
        di_guard = 1'($urandom);
        ctl      = 6'($urandom);
        aux      = 12'($urandom);
        data     = 24'($urandom);
        @(posedge clk);
        #1;
        compare_out(tag, last_w, last_d);
    endtask

    initial begin
        rst      = 1'b1;
        ce       = 1'b1;
        dtype    = 2'b01;
        di_guard = 1'b0;
        ctl      = 6'd0;
        aux      = 12'd0;
        data     = 24'd0;
        last_w   = {C0, C0, C0};
        last_d   = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        compare_out("reset", {C0, C0, C0}, 15'd0);
        rst = 1'b0;
        preload();

        repeat (3) cyc(2'b01, 1'b0, 6'b111111, 12'd0, 24'd0, {C3, C3, C3}, 15'd0, "ctl11");
        cyc(2'b01, 1'b0, {2'b10, 2'b01, 2'b00}, 12'd0, 24'd0, {C2, C1, C0}, 15'd0, "ctl_mix");

        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P00, P00, P00}, dsp(-8, -8, -8), "pix00_a");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P1S, P1S, P1S}, dsp(2, 2, 2), "pix00_b");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P00, P00, P00}, dsp(-6, -6, -6), "pix00_c");
        cyc(2'b01, 1'b0, 6'd0, 12'd0, 24'd0, {C0, C0, C0}, 15'd0, "ctl_gap");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'hFFFFFF, {PFF, PFF, PFF}, dsp(-8, -8, -8), "pixff_a");
        cyc(2'b01, 1'b0, 6'd0, 12'd0, 24'd0, {C0, C0, C0}, 15'd0, "ctl_gap2");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'hFFFFFF, {PFF, PFF, PFF}, dsp(-8, -8, -8), "pixff_b");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'hFFFFFF,
            {10'b0011111111, 10'b0011111111, 10'b0011111111}, dsp(-2, -2, -2), "pixff_c");
        stall("stall_a");
        stall("stall_b");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P1S, P1S, P1S}, dsp(8, 8, 8), "pix00_d");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'hF0F0F0,
            {10'b1000000101, 10'b1000000101, 10'b1000000101}, dsp(4, 4, 4), "pixf0");
        stall("stall_c");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'hFF0055,
            {PFF, P00, 10'b0100110011}, dsp(-4, -4, 4), "pix_mix");

        cyc(2'b00, 1'b1, 6'b000010, 12'd0, 24'd0, {GB, GB, terc[14]}, 15'd0, "gb_island");
        cyc(2'b00, 1'b0, 6'b000010, 12'd0, 24'd0, {GA, GB, GA}, 15'd0, "gb_video");

        for (int n = 0; n < 16; n++) begin
            nib0 = 4'(n);
            nib1 = 4'(n + 1);
            nib2 = 4'(n + 2);
            cyc(2'b10, 1'b0, 6'd0, {nib2, nib1, nib0}, 24'd0,
                {terc[nib2], terc[nib1], terc[nib0]}, 15'd0, "island");
        end
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P00, P00, P00}, dsp(-8, -8, -8), "pix_after_island");
        repeat (2) cyc(2'b01, 1'b0, 6'd0, 12'd0, 24'd0, {C0, C0, C0}, 15'd0, "drain");

        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P00, P00, P00}, dsp(-8, -8, -8), "pre_rst");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P1S, P1S, P1S}, dsp(2, 2, 2), "pre_rst2");
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P00, P00, P00}, dsp(-6, -6, -6), "pre_rst3");
        rst = 1'b1;
        #1;
        compare_out("rst_mid", {C0, C0, C0}, 15'd0);
        @(posedge clk);
        #1;
        compare_out("rst_hold", {C0, C0, C0}, 15'd0);
        rst = 1'b0;
        preload();
        cyc(2'b11, 1'b0, 6'd0, 12'd0, 24'h000000, {P00, P00, P00}, dsp(-8, -8, -8), "post_rst_pix");
        repeat (2) cyc(2'b01, 1'b0, 6'd0, 12'd0, 24'd0, {C0, C0, C0}, 15'd0, "drain2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
